// File: rtl/smi_flit_scale_stage_m2.sv
// smi_flit_scale_stage_m2
// SMI flit width expansion stage: packs pairs of narrow input flits into one
// output flit of twice the width. A frame end always closes the current
// output flit, so frame boundaries are preserved.
module smi_flit_scale_stage_m2 #(
    parameter int FlitWidth = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     smiInReady,
    input  logic [7:0]               smiInEofc,
    input  logic [FlitWidth*8-1:0]   smiInData,
    output logic                     smiInStop,
    output logic                     smiOutReady,
    output logic [7:0]               smiOutEofc,
    output logic [FlitWidth*16-1:0]  smiOutData,
    input  logic                     smiOutStop
);

    localparam int InBits = FlitWidth * 8;
    localparam logic [7:0] FlitBytes = 8'(FlitWidth);

    typedef enum logic {
        EMPTY,
        HALF
    } pairStateT;

    pairStateT             state;
    pairStateT             stateNext;
    logic [InBits-1:0]     holdReg;
    logic [InBits-1:0]     holdNext;

    logic                  outValid;
    logic [7:0]            outEofc;
    logic [2*InBits-1:0]   outData;

    logic                  inXfer;
    logic [7:0]            eofcClamp;
    logic                  loadOut;
    logic [7:0]            loadEofc;
    logic [2*InBits-1:0]   loadData;

    // Input is stalled only while a held output flit is being backpressured.
    assign smiInStop = outValid & smiOutStop;
    assign inXfer    = smiInReady & ~smiInStop;

    // Oversized byte counts saturate at one full narrow flit.
    always_comb begin
        eofcClamp = smiInEofc;
        if (smiInEofc > FlitBytes) begin
            eofcClamp = FlitBytes;
        end
    end

    // Pairing FSM: next state, holding register and output-flit construction.
    always_comb begin
        stateNext = state;
        holdNext  = holdReg;
        loadOut   = 1'b0;
        loadEofc  = '0;
        loadData  = '0;
        if (inXfer) begin
            unique case (state)
                EMPTY: begin
                    if (eofcClamp == 8'd0) begin
                        holdNext  = smiInData;
                        stateNext = HALF;
                    end else begin
                        loadOut  = 1'b1;
                        loadEofc = eofcClamp;
                        loadData = {{InBits{1'b0}}, smiInData};
                    end
                end
                HALF: begin
                    loadOut   = 1'b1;
                    loadData  = {smiInData, holdReg};
                    loadEofc  = (eofcClamp == 8'd0) ? 8'd0 : FlitBytes + eofcClamp;
                    stateNext = EMPTY;
                end
                default: begin
                    stateNext = EMPTY;
                end
            endcase
        end
    end

    // Pairing state and holding register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= EMPTY;
            holdReg <= '0;
        end else begin
            state   <= stateNext;
            holdReg <= holdNext;
        end
    end

    // Output register: a new flit wins over a drain in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            outValid <= 1'b0;
            outEofc  <= '0;
            outData  <= '0;
        end else if (loadOut) begin
            outValid <= 1'b1;
            outEofc  <= loadEofc;
            outData  <= loadData;
        end else if (outValid && !smiOutStop) begin
            outValid <= 1'b0;
            outEofc  <= '0;
            outData  <= '0;
        end
    end

    assign smiOutReady = outValid;
    assign smiOutEofc  = outEofc;
    assign smiOutData  = outData;

endmodule

// File: tb/tb_smi_flit_scale_stage_m2.sv
// Bench for smi_flit_scale_stage_m2 (FlitWidth = 8): directed vector table,
// hand-written reset sequences, then randomized frames checked byte-exact
// against a frame-level reference.
module tb_smi_flit_scale_stage_m2;

    localparam int FW = 8;

    logic           clk;
    logic           rstn;
    logic           smiInReady;
    logic [7:0]     smiInEofc;
    logic [63:0]    smiInData;
    logic           smiInStop;
    logic           smiOutReady;
    logic [7:0]     smiOutEofc;
    logic [127:0]   smiOutData;
    logic           smiOutStop;

    int compared   = 0;
    int mismatched = 0;

    smi_flit_scale_stage_m2 #(.FlitWidth(FW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .smiInReady (smiInReady),
        .smiInEofc  (smiInEofc),
        .smiInData  (smiInData),
        .smiInStop  (smiInStop),
        .smiOutReady(smiOutReady),
        .smiOutEofc (smiOutEofc),
        .smiOutData (smiOutData),
        .smiOutStop (smiOutStop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic         inReady;
        logic [7:0]   inEofc;
        logic [63:0]  inData;
        logic         outStop;
        logic         expInStop;
        logic         expOutReady;
        logic [7:0]   expOutEofc;
        logic [127:0] expOutData;
    } vecT;

    vecT vecs[18];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vecT mk(input logic r, input logic [7:0] e, input logic [63:0] d,
                               input logic s, input logic xs, input logic xr,
                               input logic [7:0] xe, input logic [127:0] xd);
        vecT v;
        v.inReady = r;  v.inEofc = e;  v.inData = d;  v.outStop = s;
        v.expInStop = xs; v.expOutReady = xr; v.expOutEofc = xe; v.expOutData = xd;
        return v;
    endfunction

    // Randomized-phase stimulus and frame-level reference
    logic [63:0] inDataQ[$];
    logic [7:0]  inEofcQ[$];
    logic [7:0]  expBytes[$];
    int          expLens[$];
    logic [7:0]  curBytes[$];

    initial begin
        logic [63:0] a0, a1, a2, a3, b0, b1, b2, c0, d0, d1, e0, g0, h0, h1;
        int idx, cyc, framesSeen, nb, len;
        logic accepted, prevHeld;
        logic [7:0] prevEofc;
        logic [127:0] prevData;
        logic ok;
        logic [7:0] eb;

        a0 = 64'hA007_A006_A005_A004; a1 = 64'hA117_A116_A115_A114;
        a2 = 64'hA227_A226_A225_A224; a3 = 64'hA337_A336_A335_A334;
        b0 = 64'hB00F_B00E_B00D_B00C; b1 = 64'hB11F_B11E_B11D_B11C;
        b2 = 64'hB22F_B22E_B22D_B22C; c0 = 64'hC0C1_C2C3_C4C5_C6C7;
        d0 = 64'hD0D0_1111_2222_3333; d1 = 64'hD1D1_4444_5555_6666;
        e0 = 64'hEEEE_0123_4567_89AB; g0 = 64'h6060_6060_6060_6060;
        h0 = 64'h4848_0000_4848_0000; h1 = 64'h4949_1111_4949_1111;

        // Columns: inReady, inEofc, inData, outStop | inStop, outReady, outEofc, outData
        vecs[0]  = mk(1, 0,   a0, 0, 0, 0, 0,  '0);
        vecs[1]  = mk(1, 0,   a1, 0, 0, 1, 0,  {a1, a0});
        vecs[2]  = mk(1, 0,   a2, 0, 0, 0, 0,  '0);
        vecs[3]  = mk(1, 8,   a3, 0, 0, 1, 16, {a3, a2});
        vecs[4]  = mk(0, 0,   0,  0, 0, 0, 0,  '0);
        vecs[5]  = mk(1, 0,   b0, 0, 0, 0, 0,  '0);
        vecs[6]  = mk(1, 0,   b1, 0, 0, 1, 0,  {b1, b0});
        vecs[7]  = mk(1, 5,   b2, 0, 0, 1, 5,  {64'h0, b2});
        vecs[8]  = mk(0, 0,   0,  0, 0, 0, 0,  '0);
        vecs[9]  = mk(1, 1,   c0, 0, 0, 1, 1,  {64'h0, c0});
        vecs[10] = mk(1, 0,   d0, 0, 0, 0, 0,  '0);
        vecs[11] = mk(1, 200, d1, 0, 0, 1, 16, {d1, d0});
        vecs[12] = mk(0, 0,   0,  1, 1, 1, 16, {d1, d0});
        vecs[13] = mk(1, 1,   e0, 1, 1, 1, 16, {d1, d0});
        vecs[14] = mk(1, 1,   e0, 1, 1, 1, 16, {d1, d0});
        vecs[15] = mk(1, 1,   e0, 1, 1, 1, 16, {d1, d0});
        vecs[16] = mk(1, 1,   e0, 0, 0, 1, 1,  {64'h0, e0});
        vecs[17] = mk(0, 0,   0,  0, 0, 0, 0,  '0);

        rstn = 1'b0; smiInReady = 1'b0; smiInEofc = '0; smiInData = '0; smiOutStop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outReady", 128'(smiOutReady), 128'(0));
        check("reset_outEofc",  128'(smiOutEofc),  128'(0));
        check("reset_outData",  smiOutData,        '0);
        check("reset_inStop",   128'(smiInStop),   128'(0));
        @(negedge clk);
        rstn = 1'b1;

        // Directed table
        for (int i = 0; i < 18; i++) begin
            smiInReady = vecs[i].inReady;
            smiInEofc  = vecs[i].inEofc;
            smiInData  = vecs[i].inData;
            smiOutStop = vecs[i].outStop;
            #1;
            check($sformatf("vec%0d_inStop", i), 128'(smiInStop), 128'(vecs[i].expInStop));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_outReady", i), 128'(smiOutReady), 128'(vecs[i].expOutReady));
            if (vecs[i].expOutReady) begin
                check($sformatf("vec%0d_outEofc", i), 128'(smiOutEofc), 128'(vecs[i].expOutEofc));
                check($sformatf("vec%0d_outData", i), smiOutData, vecs[i].expOutData);
            end
        end

        // Reset while holding half a pair: the half is discarded
        smiInReady = 1'b1; smiInEofc = 8'd0; smiInData = g0; smiOutStop = 1'b0;
        @(posedge clk);
        #1;
        smiInReady = 1'b0; smiOutStop = 1'b1;
        #2;
        rstn = 1'b0;
        #1;
        check("rstHalf_outReady", 128'(smiOutReady), 128'(0));
        check("rstHalf_inStop",   128'(smiInStop),   128'(0));
        @(negedge clk);
        rstn = 1'b1;
        smiOutStop = 1'b0;
        @(posedge clk);
        #1;
        smiInReady = 1'b1; smiInEofc = 8'd0; smiInData = h0;
        @(posedge clk);
        #1;
        smiInEofc = 8'd3; smiInData = h1;
        @(posedge clk);
        #1;
        smiInReady = 1'b0;
        check("rstPair_outReady", 128'(smiOutReady), 128'(1));
        check("rstPair_outEofc",  128'(smiOutEofc),  128'(11));
        check("rstPair_outData",  smiOutData,        {h1, h0});

        // Asynchronous reset drops a held output flit immediately
        smiOutStop = 1'b1;
        #2;
        rstn = 1'b0;
        #1;
        check("rstAsync_outReady", 128'(smiOutReady), 128'(0));
        check("rstAsync_outData",  smiOutData,        '0);
        @(negedge clk);
        rstn = 1'b1;
        smiOutStop = 1'b0;
        @(posedge clk);
        #1;

        // Randomized frames
        for (int f = 0; f < 1000; f++) begin
            len = $urandom_range(1, 9);
            nb = 0;
            for (int k = 0; k < len; k++) begin
                logic [63:0] d;
                logic [7:0] e;
                int n;
                d = {$urandom, $urandom};
                if (k < len - 1) begin
                    e = 8'd0;
                    n = 8;
                end else begin
                    if ($urandom_range(0, 7) == 0) e = 8'($urandom_range(9, 255));
                    else e = 8'($urandom_range(1, 8));
                    n = (e > 8) ? 8 : int'(e);
                end
                inDataQ.push_back(d);
                inEofcQ.push_back(e);
                for (int b = 0; b < n; b++) expBytes.push_back(d[8*b +: 8]);
                nb += n;
            end
            expLens.push_back(nb);
        end

        idx = 0; cyc = 0; framesSeen = 0; accepted = 1'b0; prevHeld = 1'b0;
        prevEofc = '0; prevData = '0;
        smiInReady = 1'b0;
        while (framesSeen < 1000 && cyc < 60000) begin
            if (!smiInReady || accepted) begin
                if (idx < inDataQ.size() && $urandom_range(0, 3) != 0) begin
                    smiInReady = 1'b1;
                    smiInData  = inDataQ[idx];
                    smiInEofc  = inEofcQ[idx];
                end else begin
                    smiInReady = 1'b0;
                end
            end
            smiOutStop = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            if (prevHeld) begin
                ok = smiOutReady && (smiOutEofc == prevEofc) && (smiOutData == prevData);
                check("rnd_holdStable", 128'(ok), 128'(1));
            end
            prevHeld = smiOutReady && smiOutStop;
            prevEofc = smiOutEofc;
            prevData = smiOutData;
            accepted = smiInReady && !smiInStop;
            if (accepted) idx++;
            if (smiOutReady && !smiOutStop) begin
                nb = (smiOutEofc == 0) ? 16 : ((smiOutEofc > 16) ? 16 : int'(smiOutEofc));
                for (int b = 0; b < nb; b++) curBytes.push_back(smiOutData[8*b +: 8]);
                if (smiOutEofc != 0) begin
                    if (expLens.size() == 0) begin
                        check("rnd_extraFrame", 128'(1), 128'(0));
                    end else begin
                        len = expLens.pop_front();
                        ok = (curBytes.size() == len) && (smiOutEofc <= 16);
                        for (int b = 0; b < len; b++) begin
                            eb = (expBytes.size() > 0) ? expBytes.pop_front() : 8'hxx;
                            if (b >= curBytes.size() || curBytes[b] !== eb) ok = 1'b0;
                        end
                        if (!ok)
                            $display("FAIL rnd_frame%0d: got %0d bytes expected %0d bytes (or byte content differs)",
                                     framesSeen, curBytes.size(), len);
                        compared++;
                        if (!ok) mismatched++;
                    end
                    curBytes.delete();
                    framesSeen++;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        smiInReady = 1'b0;
        smiOutStop = 1'b0;
        check("rnd_framesDelivered", 128'(framesSeen), 128'(1000));
        check("rnd_inputsConsumed",  128'(idx),        128'(inDataQ.size()));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
